// File: rtl/mda_motor_pkg.sv
// Shared register map, drive-mode encodings and default sizing for the motor PWM bank.
// Pure definitions: no logic, no latency, no flow control.
package mda_motor_pkg;

  localparam int DEF_NUM_CH   = 8;
  localparam int DEF_PERIOD_W = 16;
  localparam int DEF_WDT_W    = 24;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_DUTY   = 6'h10;
  localparam logic [5:0] ADDR_PERIOD = 6'h20;
  localparam logic [5:0] ADDR_WDT    = 6'h21;
  localparam logic [5:0] ADDR_STATUS = 6'h22;
  localparam logic [5:0] ADDR_RAMP   = 6'h23;

  typedef enum logic [1:0] {
    MODE_COAST = 2'b00,
    MODE_FWD   = 2'b01,
    MODE_REV   = 2'b10,
    MODE_BRAKE = 2'b11
  } mode_e;

  typedef struct packed {
    logic enable;
    logic in_b;
    logic in_a;
    logic pwm;
  } drive_t;

  // Bridge-driver nibble for one channel; brake shorts both legs with PWM held off.
  function automatic drive_t drive_nibble(input mode_e mode, input logic pwm);
    drive_t d;
    d = '0;
    case (mode)
      MODE_FWD:   d = '{enable: 1'b1, in_b: 1'b0, in_a: 1'b1, pwm: pwm};
      MODE_REV:   d = '{enable: 1'b1, in_b: 1'b1, in_a: 1'b0, pwm: pwm};
      MODE_BRAKE: d = '{enable: 1'b1, in_b: 1'b1, in_a: 1'b1, pwm: 1'b0};
      default:    d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mda_motor_pwm_channel.sv
// One PWM channel: effective-duty register (optional ramp), comparator and drive-mode mux.
// Effective duty changes only on load pulses; drive output is combinational from flops, no backpressure.
module mda_motor_pwm_channel
  import mda_motor_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PERIOD_W-1:0] duty_tgt,
  input  logic [PERIOD_W-1:0] cnt,
  input  logic [PERIOD_W-1:0] period,
`ifdef MDA_MOTOR_RAMP_EN
  input  logic [PERIOD_W-1:0] ramp_step,
`endif
  input  logic [1:0]          ctrl,
  input  logic                kill,
  output logic [3:0]          drive
);

  logic [PERIOD_W-1:0] eff_q, eff_d;
  logic                pwm;
  drive_t              nib;

  always_comb begin
    eff_d = eff_q;
    if (load) begin
`ifdef MDA_MOTOR_RAMP_EN
      if (ramp_step == '0) begin
        eff_d = duty_tgt;
      end else if (eff_q < duty_tgt) begin
        eff_d = (duty_tgt - eff_q > ramp_step) ? eff_q + ramp_step : duty_tgt;
      end else begin
        eff_d = (eff_q - duty_tgt > ramp_step) ? eff_q - ramp_step : duty_tgt;
      end
`else
      eff_d = duty_tgt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      eff_q <= '0;
    end else begin
      eff_q <= eff_d;
    end
  end

  // A duty at or above the period never drops below the counter, so it yields 100%.
  assign pwm   = (period != '0) && (cnt < eff_q);
  assign nib   = drive_nibble(mode_e'(ctrl), pwm);
  assign drive = kill ? 4'b0000 : nib;

endmodule

// File: rtl/mda_motor_pwm_bank.sv
// Avalon-MM motor PWM bank: shared period counter, per-channel duty/mode, sticky watchdog; MDA_MOTOR_RAMP_EN adds duty ramping.
// Reads return one cycle after the strobe, writes land on the next edge; zero wait states, no backpressure.
module mda_motor_pwm_bank
  import mda_motor_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int WDT_W    = DEF_WDT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [5:0]          addr,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [4*NUM_CH-1:0] motor_out,
  output logic                wdt_tripped
);

  logic                wr, rd, period_wr, wrap, load;
  logic [PERIOD_W-1:0] wdata_p;
  logic                unused_wdata;

  logic [1:0]          ctrl_q [NUM_CH];
  logic [1:0]          ctrl_d [NUM_CH];
  logic [PERIOD_W-1:0] duty_q [NUM_CH];
  logic [PERIOD_W-1:0] duty_d [NUM_CH];
  logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [WDT_W-1:0]    wdt_timeout_q, wdt_timeout_d, wdt_cnt_q, wdt_cnt_d;
  logic                wdt_tripped_q, wdt_tripped_d;
  logic [31:0]         readdata_q, readdata_d;
`ifdef MDA_MOTOR_RAMP_EN
  logic [PERIOD_W-1:0] ramp_step_q, ramp_step_d;
`endif

  assign wr           = chipselect & write;
  assign rd           = chipselect & read;
  assign wdata_p      = writedata[PERIOD_W-1:0];
  assign unused_wdata = ^writedata;
  assign period_wr    = wr && (addr == ADDR_PERIOD);
  assign wrap         = (period_q != '0) && (cnt_q >= period_q - PERIOD_W'(1));
  assign load         = period_wr | wrap;

  always_comb begin
    ctrl_d        = ctrl_q;
    duty_d        = duty_q;
    period_d      = period_q;
    wdt_timeout_d = wdt_timeout_q;
    wdt_cnt_d     = wdt_cnt_q;
    wdt_tripped_d = wdt_tripped_q;
    readdata_d    = '0;
    cnt_d         = cnt_q + PERIOD_W'(1);
`ifdef MDA_MOTOR_RAMP_EN
    ramp_step_d   = ramp_step_q;
`endif

    if (load || period_q == '0) begin
      cnt_d = '0;
    end

    if (wr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == ADDR_CTRL + 6'(i)) ctrl_d[i] = writedata[1:0];
        if (addr == ADDR_DUTY + 6'(i)) duty_d[i] = wdata_p;
      end
      case (addr)
        ADDR_PERIOD: period_d = wdata_p;
        ADDR_WDT:    wdt_timeout_d = writedata[WDT_W-1:0];
        ADDR_STATUS: if (writedata[0]) wdt_tripped_d = 1'b0;
`ifdef MDA_MOTOR_RAMP_EN
        ADDR_RAMP:   ramp_step_d = wdata_p;
`endif
        default: ;
      endcase
    end

    // Any write kicks the watchdog, so a write on the terminal-count cycle suppresses the trip.
    if (wr) begin
      wdt_cnt_d = '0;
    end else if (wdt_timeout_q != '0 && !wdt_tripped_q) begin
      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      if (wdt_cnt_d >= wdt_timeout_q) wdt_tripped_d = 1'b1;
    end

    if (rd) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == ADDR_CTRL + 6'(i)) readdata_d = 32'(ctrl_q[i]);
        if (addr == ADDR_DUTY + 6'(i)) readdata_d = 32'(duty_q[i]);
      end
      case (addr)
        ADDR_PERIOD: readdata_d = 32'(period_q);
        ADDR_WDT:    readdata_d = 32'(wdt_timeout_q);
        ADDR_STATUS: readdata_d = {31'b0, wdt_tripped_q};
`ifdef MDA_MOTOR_RAMP_EN
        ADDR_RAMP:   readdata_d = 32'(ramp_step_q);
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl_q[i] <= '0;
        duty_q[i] <= '0;
      end
      period_q      <= '0;
      cnt_q         <= '0;
      wdt_timeout_q <= '0;
      wdt_cnt_q     <= '0;
      wdt_tripped_q <= 1'b0;
      readdata_q    <= '0;
`ifdef MDA_MOTOR_RAMP_EN
      ramp_step_q   <= '0;
`endif
    end else begin
      ctrl_q        <= ctrl_d;
      duty_q        <= duty_d;
      period_q      <= period_d;
      cnt_q         <= cnt_d;
      wdt_timeout_q <= wdt_timeout_d;
      wdt_cnt_q     <= wdt_cnt_d;
      wdt_tripped_q <= wdt_tripped_d;
      readdata_q    <= readdata_d;
`ifdef MDA_MOTOR_RAMP_EN
      ramp_step_q   <= ramp_step_d;
`endif
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mda_motor_pwm_channel #(.PERIOD_W(PERIOD_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .duty_tgt (duty_q[i]),
      .cnt      (cnt_q),
      .period   (period_q),
`ifdef MDA_MOTOR_RAMP_EN
      .ramp_step(ramp_step_q),
`endif
      .ctrl     (ctrl_q[i]),
      .kill     (wdt_tripped_q),
      .drive    (motor_out[4*i +: 4])
    );
  end

  assign readdata    = readdata_q;
  assign wdt_tripped = wdt_tripped_q;

endmodule

// File: tb/tb_mda_motor_pwm_bank.sv
// Bench for mda_motor_pwm_bank: register/mode vector tables plus hand sequences for duty change, ramp, watchdog and reset.
// Reads and per-period duty counts go through a scoreboard queue of expected values.
module tb_mda_motor_pwm_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [5:0]  addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] motor_out;
  logic        wdt_tripped;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;
  reg_vec_t reg_tab[12];

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] duty;
    logic [3:0]  exp;
  } out_vec_t;
  out_vec_t out_tab[8];

`ifdef MDA_MOTOR_RAMP_EN
  logic [31:0] ramp_rd = 32'd5;
  int          ramp_exp[4] = '{2, 4, 6, 7};
`else
  logic [31:0] ramp_rd = 32'd0;
  int          ramp_exp[4] = '{7, 7, 7, 7};
`endif

  mda_motor_pwm_bank dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .addr       (addr),
    .writedata  (writedata),
    .readdata   (readdata),
    .motor_out  (motor_out),
    .wdt_tripped(wdt_tripped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete in time");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; addr = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    sb_q.push_back('{name: name, exp: exp});
    chipselect = 1'b1; read = 1'b1; addr = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    e = sb_q.pop_front();
    check(e.name, readdata, e.exp);
  endtask

  initial begin
    int hi;
    int exp_eff;
    sb_t e;

    reg_tab[0]  = '{6'h10, 32'h0000_1234, 32'h0000_1234};
    reg_tab[1]  = '{6'h00, 32'h0000_0007, 32'h0000_0003};
    reg_tab[2]  = '{6'h07, 32'h0000_0002, 32'h0000_0002};
    reg_tab[3]  = '{6'h08, 32'h0000_0003, 32'h0000_0000};
    reg_tab[4]  = '{6'h17, 32'h0000_ABCD, 32'h0000_ABCD};
    reg_tab[5]  = '{6'h18, 32'h0000_5555, 32'h0000_0000};
    reg_tab[6]  = '{6'h20, 32'h0001_0005, 32'h0000_0005};
    reg_tab[7]  = '{6'h21, 32'h1234_5678, 32'h0034_5678};
    reg_tab[8]  = '{6'h23, 32'h0000_0005, ramp_rd};
    reg_tab[9]  = '{6'h30, 32'h0000_0001, 32'h0000_0000};
    reg_tab[10] = '{6'h22, 32'h0000_0000, 32'h0000_0000};
    reg_tab[11] = '{6'h3F, 32'hFFFF_FFFF, 32'h0000_0000};

    out_tab[0] = '{2'b00, 32'd12, 4'b0000};
    out_tab[1] = '{2'b01, 32'd12, 4'b1011};
    out_tab[2] = '{2'b10, 32'd12, 4'b1101};
    out_tab[3] = '{2'b11, 32'd12, 4'b1110};
    out_tab[4] = '{2'b01, 32'd0,  4'b1010};
    out_tab[5] = '{2'b10, 32'd0,  4'b1100};
    out_tab[6] = '{2'b01, 32'd10, 4'b1011};
    out_tab[7] = '{2'b00, 32'd0,  4'b0000};

    reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    addr = '0; writedata = '0;
    repeat (3) tick();
    check("rst_motor_out", motor_out, 32'h0);
    check("rst_wdt", {31'b0, wdt_tripped}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    reset = 1'b1;
    tick();
    bus_read(6'h10, 32'h0, "rst_duty0");
    bus_read(6'h20, 32'h0, "rst_period");

    for (int v = 0; v < 12; v++) begin
      bus_write(reg_tab[v].addr, reg_tab[v].wdata);
      bus_read(reg_tab[v].addr, reg_tab[v].exp, $sformatf("reg_vec%0d", v));
    end
    bus_write(6'h21, 32'd0);
    bus_write(6'h23, 32'd0);

    for (int v = 0; v < 8; v++) begin
      bus_write(6'h00, {30'b0, out_tab[v].mode});
      bus_write(6'h10, out_tab[v].duty);
      bus_write(6'h20, 32'd10);
      for (int c = 0; c < 12; c++) begin
        check($sformatf("out_vec%0d_c%0d", v, c), {28'b0, motor_out[3:0]}, {28'b0, out_tab[v].exp});
        tick();
      end
    end

    bus_write(6'h00, 32'd1);
    bus_write(6'h10, 32'd3);
    bus_write(6'h20, 32'd10);
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      check($sformatf("duty3_c%0d", c), {28'b0, motor_out[3:0]}, {28'b0, 3'b101, (c % 10) < 3});
      hi += int'(motor_out[0]);
      tick();
    end
    check("duty3_high_count", 32'(hi), 32'd6);

    bus_write(6'h02, 32'd1);
    bus_write(6'h12, 32'd3);
    bus_write(6'h20, 32'd10);
    for (int c = 0; c < 20; c++) begin
      exp_eff = (c < 10) ? 3 : 7;
      check($sformatf("duty_chg_c%0d", c), {28'b0, motor_out[11:8]}, {28'b0, 3'b101, (c % 10) < exp_eff});
      if (c == 5) bus_write(6'h12, 32'd7);
      else tick();
    end

    bus_write(6'h23, 32'd2);
    bus_write(6'h01, 32'd1);
    bus_write(6'h11, 32'd0);
    bus_write(6'h20, 32'd10);
    bus_write(6'h11, 32'd7);
    repeat (9) tick();
    for (int p = 0; p < 4; p++) sb_q.push_back('{name: $sformatf("ramp_period%0d", p), exp: 32'(ramp_exp[p])});
    for (int p = 0; p < 4; p++) begin
      hi = 0;
      for (int k = 0; k < 10; k++) begin
        hi += int'(motor_out[4]);
        tick();
      end
      e = sb_q.pop_front();
      check(e.name, 32'(hi), e.exp);
    end
    bus_write(6'h23, 32'd0);

    bus_write(6'h20, 32'd0);
    for (int c = 0; c < 12; c++) begin
      check($sformatf("period0_pwm_c%0d", c), motor_out & 32'h1111_1111, 32'h0);
      tick();
    end
    check("period0_ch0_nibble", {28'b0, motor_out[3:0]}, 32'hA);

    bus_write(6'h10, 32'd12);
    bus_write(6'h20, 32'd10);
    bus_write(6'h21, 32'd100);
    repeat (99) tick();
    check("wdt_before_timeout", {31'b0, wdt_tripped}, 32'h0);
    check("wdt_outputs_live", {28'b0, motor_out[3:0]}, 32'hB);
    tick();
    check("wdt_at_timeout", {31'b0, wdt_tripped}, 32'h1);
    check("wdt_outputs_off", motor_out, 32'h0);
    repeat (5) tick();
    check("wdt_sticky", {31'b0, wdt_tripped}, 32'h1);
    bus_read(6'h22, 32'h1, "status_tripped");
    bus_read(6'h10, 32'd12, "duty0_retained");
    bus_write(6'h22, 32'h1);
    check("wdt_cleared", {31'b0, wdt_tripped}, 32'h0);
    check("wdt_outputs_resume", {28'b0, motor_out[3:0]}, 32'hB);
    repeat (99) tick();
    bus_write(6'h00, 32'd1);
    check("wdt_write_wins", {31'b0, wdt_tripped}, 32'h0);
    bus_write(6'h21, 32'd0);
    repeat (200) tick();
    check("wdt_disabled", {31'b0, wdt_tripped}, 32'h0);

    bus_read(6'h10, 32'd12, "pre_reset_read");
    reset = 1'b0; chipselect = 1'b1; write = 1'b1; addr = 6'h10; writedata = 32'd5;
    tick();
    check("midrst_motor_out", motor_out, 32'h0);
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_wdt", {31'b0, wdt_tripped}, 32'h0);
    reset = 1'b1; chipselect = 1'b0; write = 1'b0;
    tick();
    bus_read(6'h10, 32'h0, "midrst_duty0_write_lost");
    bus_read(6'h00, 32'h0, "midrst_ctrl0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
